rv_fifo: RTL

- Small synchronous valid/ready FIFO. It is the design block that the team's bound property modules attach to.
- Gives the formal flow a non-trivial sequential DUT: pointers, count, full/empty, and a handshake on both sides.
- Sits between an upstream producer and a downstream consumer. It decouples them by up to DEPTH words.
- Written so that two implementations (flop-array and alternative) can be proven equivalent on the same port list.

---
 rtl/rv_fifo_pkg.sv | 15 +
 rtl/rv_fifo_mem.sv | 33 +++
 rtl/rv_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/rv_fifo_pkg.sv
// Shared helpers for the rv_fifo valid/ready FIFO.
// Only DEPTH-independent functions live here; widths are derived in the module.
package rv_fifo_pkg;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit depth_legal(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// DEPTH x DATA_W flop storage, one write port and one combinational read port.
// All entries clear on reset so the read port never shows X.
module rv_fifo_mem
    import rv_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PW     = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rv_fifo.sv
// Valid/ready FIFO: pointers, occupancy count and both handshakes.
// Flags depend only on registered count; no same-cycle bypass when empty.
module rv_fifo
    import rv_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("rv_fifo: DEPTH must be a power of two >= 2");
    end

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic push, pop;
    logic [DATA_W-1:0] rdata;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    rv_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_data = out_valid ? rdata : '0;
    assign count    = count_q;

endmodule
